// File: rtl/sio_pkg.sv
// Shared types, defaults and helpers for the serial frame scheduler.
package sio_pkg;

  localparam int unsigned SIO_WORDW     = 10;
  localparam int unsigned SIO_GAP_RESET = 20;
  localparam int unsigned CNTW          = 5;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } sio_state_e;

  // Inter-frame gap is never shorter than a data word, so a zero run
  // always outlasts any run inside the data bits.
  function automatic logic [CNTW-1:0] gap_clamp(input logic [CNTW-1:0] gaplen,
                                                input logic [CNTW-1:0] wordw);
    return (gaplen > wordw) ? gaplen : wordw;
  endfunction

endpackage

// File: rtl/sio_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the last grant.
module sio_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx
);

  logic            found;
  logic [IDXW-1:0] cand;

  // First valid requester in rotated order wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(last_grant) + k) % NREQ);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sio_frame_scheduler.sv
// Serialises words from NREQ requesters onto one line as start bit plus
// MSB-first data, separated by guaranteed zero gaps.
module sio_frame_scheduler
  import sio_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WORDW     = SIO_WORDW,
  parameter int unsigned GAP_RESET = SIO_GAP_RESET,
  localparam int unsigned IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  SioClk,
  input  logic                  SioRst,
  input  logic [NREQ-1:0]       ReqValid,
  input  logic [NREQ*WORDW-1:0] ReqData,
  output logic [NREQ-1:0]       ReqReady,
  input  logic [4:0]            GapLen,
  output logic                  SioDat,
  output logic                  Busy,
  output logic [IDXW-1:0]       CurReq
);

  localparam int unsigned BITW = (WORDW > 1) ? $clog2(WORDW) : 1;

  sio_state_e       state;
  logic [CNTW-1:0]  cnt;
  logic [WORDW-1:0] shifter;
  logic [BITW-1:0]  bitcnt;
  logic [IDXW-1:0]  last_grant;
  logic [NREQ-1:0]  grant;
  logic [IDXW-1:0]  grant_idx;
  logic             gap_open;
  logic [WORDW-1:0] word [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign word[g] = ReqData[g*WORDW +: WORDW];
  end

  sio_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid      (ReqValid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign gap_open = (state == ST_GAP) && (cnt == '0) && !SioRst;
  assign ReqReady = gap_open ? grant : '0;
  assign Busy     = ((state == ST_START) || (state == ST_DATA)) && !SioRst;

  // Frame sequencer: gap countdown, grant capture, start bit, data shift-out.
  always_ff @(posedge SioClk) begin
    if (SioRst) begin
      state      <= ST_GAP;
      cnt        <= CNTW'(GAP_RESET);
      SioDat     <= 1'b0;
      last_grant <= IDXW'(NREQ-1);
      CurReq     <= '0;
      shifter    <= '0;
      bitcnt     <= '0;
    end else begin
      case (state)
        ST_GAP: begin
          SioDat <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (|(ReqReady & ReqValid)) begin
            shifter    <= word[grant_idx];
            CurReq     <= grant_idx;
            last_grant <= grant_idx;
            SioDat     <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          SioDat  <= shifter[WORDW-1];
          shifter <= {shifter[WORDW-2:0], 1'b0};
          bitcnt  <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          if (bitcnt == BITW'(WORDW-1)) begin
            SioDat <= 1'b0;
            cnt    <= gap_clamp(GapLen, CNTW'(WORDW));
            state  <= ST_GAP;
          end else begin
            SioDat  <= shifter[WORDW-1];
            shifter <= {shifter[WORDW-2:0], 1'b0};
            bitcnt  <= bitcnt + 1'b1;
          end
        end
        default: begin
          SioDat <= 1'b0;
          cnt    <= gap_clamp(GapLen, CNTW'(WORDW));
          state  <= ST_GAP;
        end
      endcase
    end
  end

endmodule
